ir_assembler: RTL

Parametrised instruction register that assembles a `BYTES`-wide instruction from an 8-bit byte stream under a valid/ready handshake. It tracks fill state with a small FSM and holds the completed word until the control unit consumes it. It keeps the established FunSel command set (clear / load / decrement / increment) and sits between the memory data bus and the control-unit decoder, replacing the fixed 16-bit LH-selected instruction register.

---
 rtl/ir_pkg.sv | 21 ++
 rtl/ir_fill_ctrl.sv | 68 ++++++
 rtl/ir_assembler.sv | 76 +++++++
 3 files changed

// File: rtl/ir_pkg.sv
// Shared definitions for the byte-stream instruction register: FunSel codes,
// fill-state enum and the lane-pointer width helper.
package ir_pkg;

  localparam logic [1:0] FS_CLEAR = 2'b00;
  localparam logic [1:0] FS_LOAD  = 2'b01;
  localparam logic [1:0] FS_DEC   = 2'b10;
  localparam logic [1:0] FS_INC   = 2'b11;

  typedef enum logic [1:0] {
    IR_IDLE = 2'd0,
    IR_FILL = 2'd1,
    IR_FULL = 2'd2
  } ir_state_e;

  // Pointer width; a single-lane register still carries a 1-bit pointer.
  function automatic int lane_w(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

endpackage

// File: rtl/ir_fill_ctrl.sv
// Fill-state FSM and lane pointer: produces InReady, Valid, Lane and the
// one-hot lane write enable for the data lanes in the top level.
module ir_fill_ctrl
  import ir_pkg::*;
#(
  parameter int BYTES     = 2,
  parameter int MSB_FIRST = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      e,
  input  logic [1:0]                fun_sel,
  input  logic                      in_valid,
  input  logic                      consume,
  output logic                      in_ready,
  output logic                      valid,
  output logic [lane_w(BYTES)-1:0]  lane,
  output logic [BYTES-1:0]          lane_we
);

  localparam int LW = lane_w(BYTES);

  ir_state_e         state_q, state_d;
  logic [LW-1:0]     ptr_q, ptr_d;
  logic [LW-1:0]     target;
  logic              accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IR_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    in_ready = e && (fun_sel == FS_LOAD) && (state_q != IR_FULL);
    accept   = in_valid && in_ready;
    target   = (MSB_FIRST != 0) ? (LW'(BYTES - 1) - ptr_q) : ptr_q;
    lane_we  = '0;
    for (int i = 0; i < BYTES; i++)
      lane_we[i] = accept && (target == LW'(i));

    // Clear wins over everything, including a same-cycle Consume.
    if (e && (fun_sel == FS_CLEAR)) begin
      state_d = IR_IDLE;
      ptr_d   = '0;
    end else if (accept) begin
      if (ptr_q == LW'(BYTES - 1)) begin
        state_d = IR_FULL;
        ptr_d   = '0;
      end else begin
        state_d = IR_FILL;
        ptr_d   = ptr_q + LW'(1);
      end
    end else if (consume && (state_q == IR_FULL)) begin
      state_d = IR_IDLE;
    end
  end

  assign valid = (state_q == IR_FULL);
  assign lane  = ptr_q;

endmodule

// File: rtl/ir_assembler.sv
// Instruction register assembled from an 8-bit byte stream; holds the data
// lanes and inc/dec arithmetic. Optional parity check under IR_PARITY_EN.
module ir_assembler
  import ir_pkg::*;
#(
  parameter int BYTES     = 2,
  parameter int MSB_FIRST = 0
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      E,
  input  logic [1:0]                FunSel,
  input  logic [7:0]                Input,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic                      Consume,
  output logic [8*BYTES-1:0]        IROut,
  output logic                      Valid,
`ifdef IR_PARITY_EN
  input  logic                      InParity,
  output logic                      ParErr,
`endif
  output logic [lane_w(BYTES)-1:0]  Lane
);

  logic [8*BYTES-1:0] ir_q;
  logic [BYTES-1:0]   lane_we;

  ir_fill_ctrl #(.BYTES(BYTES), .MSB_FIRST(MSB_FIRST)) u_fill (
    .clk      (Clock),
    .rst      (Reset),
    .e        (E),
    .fun_sel  (FunSel),
    .in_valid (InValid),
    .consume  (Consume),
    .in_ready (InReady),
    .valid    (Valid),
    .lane     (Lane),
    .lane_we  (lane_we)
  );

  // Lane writes only happen under FS_LOAD, so they never collide with clear/inc/dec.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ir_q <= '0;
    end else if (E && (FunSel == FS_CLEAR)) begin
      ir_q <= '0;
    end else if (E && (FunSel == FS_DEC)) begin
      ir_q <= ir_q - 1'b1;
    end else if (E && (FunSel == FS_INC)) begin
      ir_q <= ir_q + 1'b1;
    end else begin
      for (int i = 0; i < BYTES; i++)
        if (lane_we[i]) ir_q[8*i +: 8] <= Input;
    end
  end

  assign IROut = ir_q;

`ifdef IR_PARITY_EN
  logic par_q;

  // Sticky: only clear or Reset drop it.
  always_ff @(posedge Clock) begin
    if (Reset)
      par_q <= 1'b0;
    else if (E && (FunSel == FS_CLEAR))
      par_q <= 1'b0;
    else if (InValid && InReady && (^{Input, InParity}))
      par_q <= 1'b1;
  end

  assign ParErr = par_q;
`endif

endmodule
